// File: rtl/uart_flash_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_flash_loader
// Description : 8N1 UART receiver that streams a program image to the fetch
//               stage. Raises flash on the first valid start bit and drops it
//               after the line has been idle for IDLE_TIMEOUT_CYCLES clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_flash_loader #(
  parameter int unsigned CLK_FREQ            = 100_000_000,
  parameter int unsigned BAUD_RATE           = 115_200,
  parameter int unsigned IDLE_TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  uart_data,
  output logic        uart_received,
  output logic        flash,
  output logic        frame_error,
  output logic [31:0] byte_count
);

  localparam int unsigned c_clks_per_bit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned c_half         = c_clks_per_bit / 2;
  localparam int unsigned c_baud_w       = (c_clks_per_bit > 1) ? $clog2(c_clks_per_bit) : 1;
  localparam int unsigned c_to_w         = (IDLE_TIMEOUT_CYCLES > 1) ? $clog2(IDLE_TIMEOUT_CYCLES) : 1;
  localparam logic [c_baud_w-1:0] c_bit_last  = c_baud_w'(c_clks_per_bit - 1);
  localparam logic [c_baud_w-1:0] c_half_last = c_baud_w'(c_half - 1);
  localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(IDLE_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_rx_meta, r_rx_s;
  logic [c_baud_w-1:0] r_baud, w_baud_nxt;
  logic [2:0]          r_idx, w_idx_nxt;
  logic [7:0]          r_shift, w_shift_nxt;
  logic [7:0]          r_data, w_data_nxt;
  logic                r_recv, w_recv_nxt;
  logic                r_fe, w_fe_nxt;
  logic                r_flash, w_flash_nxt;
  logic [31:0]         r_count, w_count_nxt;
  logic [c_to_w-1:0]   r_to, w_to_nxt;

  // Two-flop synchronizer for the asynchronous rx line; resets to idle-high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_recv  <= 1'b0;
      r_fe    <= 1'b0;
      r_flash <= 1'b0;
      r_count <= '0;
      r_to    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_recv  <= w_recv_nxt;
      r_fe    <= w_fe_nxt;
      r_flash <= w_flash_nxt;
      r_count <= w_count_nxt;
      r_to    <= w_to_nxt;
    end
  end

  // Next-state, bit sampling, byte delivery and flash/timeout control
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_recv_nxt  = 1'b0;
    w_fe_nxt    = 1'b0;
    w_flash_nxt = r_flash;
    w_count_nxt = r_count;
    w_to_nxt    = r_to;

    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          // A falling edge takes priority over expiry on the same cycle, so
          // a frame starting exactly at timeout keeps flash mode alive.
          w_state_nxt = S_START;
          w_baud_nxt  = '0;
        end else if (r_flash) begin
          if (r_to == c_to_last) begin
            w_flash_nxt = 1'b0;
            w_to_nxt    = '0;
          end else begin
            w_to_nxt = r_to + 1'b1;
          end
        end
      end

      S_START: begin
        if (r_baud == c_half_last) begin
          w_baud_nxt = '0;
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
            w_to_nxt    = '0;
            if (!r_flash) begin
              w_flash_nxt = 1'b1;
              w_count_nxt = '0;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      S_DATA: begin
        if (r_baud == c_bit_last) begin
          w_baud_nxt         = '0;
          w_shift_nxt[r_idx] = r_rx_s;
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      S_STOP: begin
        if (r_baud == c_bit_last) begin
          w_baud_nxt  = '0;
          w_to_nxt    = '0;
          w_state_nxt = S_IDLE;
          if (r_rx_s) begin
            w_data_nxt  = r_shift;
            w_recv_nxt  = 1'b1;
            w_count_nxt = r_count + 32'd1;
          end else begin
            w_fe_nxt = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign uart_data     = r_data;
  assign uart_received = r_recv;
  assign flash         = r_flash;
  assign frame_error   = r_fe;
  assign byte_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_flash_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_flash_loader
// Description : Directed bench for uart_flash_loader at 10 clocks per bit and
//               a 50-clock idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_flash_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [7:0]  uart_data;
  logic        uart_received;
  logic        flash;
  logic        frame_error;
  logic [31:0] byte_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int e0    = 0;

  int n_rx = 0, n_fe = 0, n_fall = 0, dbl = 0;
  int strobe_cyc = -1, rise_cyc = -1, fall_cyc = -1;
  logic prev_recv = 1'b0, prev_flash = 1'b0;
  logic [7:0] rx_log[$];

  uart_flash_loader #(
    .CLK_FREQ(1000),
    .BAUD_RATE(100),
    .IDLE_TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .uart_data(uart_data),
    .uart_received(uart_received),
    .flash(flash),
    .frame_error(frame_error),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled on the falling edge
  always @(negedge clk) begin
    if (uart_received) begin
      n_rx++;
      rx_log.push_back(uart_data);
      strobe_cyc = cyc;
    end
    if (uart_received && prev_recv) dbl++;
    if (frame_error) n_fe++;
    if (flash && !prev_flash) rise_cyc = cyc;
    if (!flash && prev_flash) begin
      fall_cyc = cyc;
      n_fall++;
    end
    prev_recv  = uart_received;
    prev_flash = flash;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first and the stop bit, 10 clocks each,
  // for nclk clocks; the line returns high afterwards.
  task automatic drive_frame(input logic [7:0] d, input logic stop, input int nclk);
    logic [9:0] f;
    f  = {stop, d, 1'b0};
    e0 = cyc;
    for (int i = 0; i < nclk; i++) begin
      rx = f[i/10];
      tick(1);
    end
    rx = 1'b1;
  endtask

  int a, nf, base;

  initial begin
    tick(4);
    check("rst_data",  32'(uart_data), 32'h0);
    check("rst_recv",  32'(uart_received), 32'h0);
    check("rst_flash", 32'(flash), 32'h0);
    check("rst_fe",    32'(frame_error), 32'h0);
    check("rst_count", byte_count, 32'h0);
    rst = 1'b0;
    tick(5);

    // Glitch shorter than half a bit
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    check("glitch_flash", 32'(flash), 32'h0);
    check("glitch_nrx",   32'(n_rx), 32'd0);
    check("glitch_count", byte_count, 32'h0);

    // Good byte 0xA5
    drive_frame(8'hA5, 1'b1, 100);
    check("a5_data",   32'(uart_data), 32'hA5);
    check("a5_count",  byte_count, 32'd1);
    check("a5_nrx",    32'(n_rx), 32'd1);
    check("a5_strobe", 32'(strobe_cyc), 32'(e0 + 98));
    check("a5_rise",   32'(rise_cyc), 32'(e0 + 8));
    check("a5_fe",     32'(n_fe), 32'd0);
    check("a5_flash",  32'(flash), 32'h1);

    // 0x3C with a low stop bit
    drive_frame(8'h3C, 1'b0, 100);
    tick(20);
    check("fe_nfe",   32'(n_fe), 32'd1);
    check("fe_nrx",   32'(n_rx), 32'd1);
    check("fe_data",  32'(uart_data), 32'hA5);
    check("fe_count", byte_count, 32'd1);
    check("fe_flash", 32'(flash), 32'h1);
    tick(200);
    check("fe_timeout", 32'(flash), 32'h0);

    // Four back-to-back bytes then idle
    base = rx_log.size();
    drive_frame(8'h01, 1'b1, 100);
    a = e0;
    drive_frame(8'h02, 1'b1, 100);
    drive_frame(8'h03, 1'b1, 100);
    drive_frame(8'h04, 1'b1, 100);
    tick(60);
    check("b4_rise",  32'(rise_cyc), 32'(a + 8));
    check("b4_n",     32'(rx_log.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < rx_log.size())
        check("b4_data", 32'(rx_log[base + i]), 32'(i + 1));
    end
    check("b4_count", byte_count, 32'd4);
    check("b4_fall",  32'(fall_cyc), 32'(e0 + 148));

    // Reset during bit 4
    drive_frame(8'h5A, 1'b1, 55);
    check("pre_rst_flash", 32'(flash), 32'h1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_data",  32'(uart_data), 32'h0);
    check("mid_rst_recv",  32'(uart_received), 32'h0);
    check("mid_rst_flash", 32'(flash), 32'h0);
    check("mid_rst_fe",    32'(frame_error), 32'h0);
    check("mid_rst_count", byte_count, 32'h0);
    rst = 1'b0;
    tick(5);
    base = n_rx;
    drive_frame(8'h5A, 1'b1, 100);
    check("5a_nrx",   32'(n_rx - base), 32'd1);
    check("5a_data",  32'(uart_data), 32'h5A);
    check("5a_count", byte_count, 32'd1);
    check("5a_flash", 32'(flash), 32'h1);
    check("5a_rise",  32'(rise_cyc), 32'(e0 + 8));

    // Timeout, then a new download restarts the count
    tick(100);
    check("to_flash", 32'(flash), 32'h0);
    drive_frame(8'hFF, 1'b1, 100);
    a = e0;
    check("ff_data",  32'(uart_data), 32'hFF);
    check("ff_count", byte_count, 32'd1);
    check("ff_rise",  32'(rise_cyc), 32'(a + 8));

    // Next start edge lands on the expiry cycle: flash must not drop
    tick(45);
    nf = n_fall;
    drive_frame(8'h11, 1'b1, 100);
    check("exp_e0",    32'(e0), 32'(a + 145));
    check("exp_nfall", 32'(n_fall), 32'(nf));
    check("exp_flash", 32'(flash), 32'h1);
    check("exp_data",  32'(uart_data), 32'h11);
    check("exp_count", byte_count, 32'd2);
    tick(60);
    check("exp_fall",  32'(fall_cyc), 32'(e0 + 148));
    check("no_double_strobe", 32'(dbl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
